// File: rtl/fpu_stream_buffer_pkg.sv
// Shared types and sizing helpers for the FPU stream buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int DW_DEFAULT = 32;

  // One result-FIFO entry: exception flag above the result word
  typedef struct packed {
    logic                  exp;
    logic [DW_DEFAULT-1:0] data;
  } fpu_res_t;

  // Pointer width for a power-of-two FIFO: index bits plus one wrap bit
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpu_stream_buffer_if.sv
// Instruction, FPU-core and result streams of the FPU stream buffer.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready; the core side cannot stall.
interface fpu_stream_buffer_if
  import fpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instruction;
  logic          core_valid;
  logic [DW-1:0] core_instruction;
  logic          core_res_valid;
  logic [DW-1:0] core_result;
  logic          core_exp_flag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_exp_flag;

  // Environment side: producer of instructions, the FPU core and the consumer
  modport master (
    output in_valid, in_instruction, core_res_valid, core_result, core_exp_flag, out_ready,
    input  in_ready, core_valid, core_instruction, out_valid, out_result, out_exp_flag
  );

  // Buffer side
  modport slave (
    input  in_valid, in_instruction, core_res_valid, core_result, core_exp_flag, out_ready,
    output in_ready, core_valid, core_instruction, out_valid, out_result, out_exp_flag
  );

endinterface

// File: rtl/fpu_stream_buffer_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer advance; the wrap bit distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fpu_stream_buffer.sv
// Buffers instructions, issues to a fixed-latency FPU core only when a result slot is reserved.
// Latency: accept T -> core_valid T+1 -> core_res_valid T+1+LATENCY -> out_valid T+2+LATENCY.
// Backpressure: in_ready drops when the instruction FIFO is full; issue stalls on credit.
module fpu_stream_buffer
  import fpu_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  fpu_stream_buffer_if.slave     bus,
  input  logic                   exp_clear,
  output logic                   exp_sticky,
  output logic                   err_unexpected,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = ptr_w(DEPTH);

  logic          ifull, iempty;
  logic [PW-1:0] icount;
  logic [DW-1:0] ihead;
  logic          in_push;

  logic          rfull, rempty;
  logic [PW-1:0] rcount;
  logic [DW:0]   rhead;
  logic          res_push;
  logic          res_pop;
  logic          res_unexpected;

  logic [LATENCY-1:0] trk;
  logic [LATENCY:0]   trk_ext;
  int                 inflight;
  logic               credit_ok;

  assign bus.in_ready = !ifull && !rst;
  assign in_push      = bus.in_valid && bus.in_ready;

  sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_ififo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_push),
    .push_data (bus.in_instruction),
    .pop       (bus.core_valid),
    .pop_data  (ihead),
    .full      (ifull),
    .empty     (iempty),
    .count     (icount)
  );

  assign level = icount;

  // Count issues still inside the core; the oldest bit is the one returning now
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LATENCY; i++) begin
      if (trk[i]) inflight++;
    end
  end

  // rcount still includes an entry popping this cycle, keeping the check conservative
  assign credit_ok            = (int'(rcount) + inflight) < DEPTH;
  assign bus.core_valid       = !iempty && credit_ok && !rst;
  assign bus.core_instruction = ihead;

  assign trk_ext = {trk, bus.core_valid};

  // Issue tracker: one bit per core pipeline stage
  always_ff @(posedge clk) begin
    if (rst) trk <= '0;
    else     trk <= trk_ext[LATENCY-1:0];
  end

  assign res_push       = bus.core_res_valid && trk[LATENCY-1] && !rfull;
  assign res_unexpected = bus.core_res_valid && !trk[LATENCY-1];
  assign res_pop        = bus.out_valid && bus.out_ready;

  sync_fifo #(.WIDTH(DW + 1), .DEPTH(DEPTH)) u_rfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_data ({bus.core_exp_flag, bus.core_result}),
    .pop       (res_pop),
    .pop_data  (rhead),
    .full      (rfull),
    .empty     (rempty),
    .count     (rcount)
  );

  assign bus.out_valid    = !rempty;
  assign bus.out_result   = rhead[DW-1:0];
  assign bus.out_exp_flag = rhead[DW];

  // Sticky exception: a flagged push beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)                               exp_sticky <= 1'b0;
    else if (res_push && bus.core_exp_flag) exp_sticky <= 1'b1;
    else if (exp_clear)                    exp_sticky <= 1'b0;
  end

  // Protocol error: a result with no matching issue; only reset clears it
  always_ff @(posedge clk) begin
    if (rst)                 err_unexpected <= 1'b0;
    else if (res_unexpected) err_unexpected <= 1'b1;
  end

endmodule
